// File: rtl/mem_log_pkg.sv
// mem_log_pkg: shared constants for the sample-logging BRAM controller.
//   - FSM state encoding (legacy-compatible 2-bit localparams)
//   - default widths for the controller, its interface and sub-module
//   - host read latency (request to valid)
//   - host_owns(): which states give the BRAM port to the host
package mem_log_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_FULL    = 2'd3;

    localparam int ADDR_WIDTH_DEF  = 15;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int DECIM_WIDTH_DEF = 8;

    // Request cycle -> address register -> BRAM output register.
    localparam int RD_LAT = 2;

    function automatic logic host_owns(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_FULL);
    endfunction

endpackage

// File: rtl/mem_log_ctrl_if.sv
// mem_log_ctrl_if: host read port plus the single BRAM port of the logger.
//   Host side : i_rd_req, i_rd_addr -> o_rd_data (32b, zero-extended), o_rd_valid
//   BRAM side : o_bram_addr, o_bram_we, o_bram_wdata -> i_bram_rdata (1-cycle latency)
// Modports: slave = the controller, master = host / BRAM environment.
interface mem_log_ctrl_if
    import mem_log_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic [31:0]           o_rd_data;
    logic                  o_rd_valid;

    logic [ADDR_WIDTH-1:0] o_bram_addr;
    logic                  o_bram_we;
    logic [DATA_WIDTH-1:0] o_bram_wdata;
    logic [DATA_WIDTH-1:0] i_bram_rdata;

    modport slave (
        input  i_rd_req, i_rd_addr, i_bram_rdata,
        output o_rd_data, o_rd_valid, o_bram_addr, o_bram_we, o_bram_wdata
    );

    modport master (
        output i_rd_req, i_rd_addr, i_bram_rdata,
        input  o_rd_data, o_rd_valid, o_bram_addr, o_bram_we, o_bram_wdata
    );

endinterface

// File: rtl/mem_log_decim.sv
// mem_log_decim: decimation counter for the capture stream.
//   clk, i_rst  : clock, synchronous active-high reset
//   i_valid     : sample strobe, already gated to the capture window
//   i_load      : start of a run; clears the counter so the first sample is kept
//   i_decim     : latched decimation factor (keep 1 of every i_decim+1)
//   o_keep      : combinational, high when the current valid sample is kept
module mem_log_decim
    import mem_log_pkg::*;
#(
    parameter int DECIM_WIDTH = DECIM_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_load,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    output logic                   o_keep
);

    logic [DECIM_WIDTH-1:0] cnt;

    assign o_keep = i_valid && (cnt == '0);

    always_ff @(posedge clk) begin
        if (i_rst || i_load) begin
            cnt <= '0;
        end else if (i_valid) begin
            cnt <= (cnt == '0) ? i_decim : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mem_log_ctrl.sv
// mem_log_ctrl: sequencer and BRAM port arbiter for the sample logger.
// A rising edge on i_run_log latches i_decim and starts a capture of the
// decimated filter stream into the BRAM; when the last address is written
// the port is handed to the host's pipelined read interface (o_mem_full).
//   clk, i_rst       : clock, synchronous active-high reset
//   i_sample_valid   : filter strobe;  i_sample : filter sample
//   i_decim          : decimation factor, latched on the run edge
//   i_run_log        : run level, rising edge starts a capture
//   i_trigger        : capture trigger (only with LOG_TRIGGER_EN)
//   bus (slave)      : host read port and BRAM port
//   o_mem_full       : capture complete;  o_busy : armed or capturing
// Build option: define LOG_TRIGGER_EN to insert the ARMED state, which
// waits for i_trigger before capturing. Undefined, a run edge goes straight
// to CAPTURE and i_trigger is ignored.
module mem_log_ctrl
    import mem_log_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DECIM_WIDTH = DECIM_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_sample_valid,
    input  logic [DATA_WIDTH-1:0]  i_sample,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    input  logic                   i_run_log,
    input  logic                   i_trigger,
    mem_log_ctrl_if.slave          bus,
    output logic                   o_mem_full,
    output logic                   o_busy
);

`ifdef LOG_TRIGGER_EN
    localparam logic [1:0] RUN_STATE = ST_ARMED;
`else
    localparam logic [1:0] RUN_STATE = ST_CAPTURE;
    logic unused_trigger;
    assign unused_trigger = i_trigger;
`endif

    logic [1:0]             state;
    logic                   run_d;
    logic                   run_edge;
    logic                   load;
    logic [DECIM_WIDTH-1:0] decim_lat;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   full_pend;
    logic                   mem_full;
    logic                   cap_valid;
    logic                   keep;
    logic                   host_rd;

    logic                   bram_we_p0;
    logic [ADDR_WIDTH-1:0]  bram_addr_p0;
    logic [DATA_WIDTH-1:0]  bram_wdata_p0;
    logic [RD_LAT-1:0]      rd_vld_p;
    logic [RD_LAT-1:0]      rd_host_p;

    assign run_edge = i_run_log && !run_d;
    assign load     = run_edge && host_owns(state);

    // full_pend covers the cycle the last write is on the port: the state is
    // still CAPTURE (capture keeps the port) but no further sample may land.
    assign cap_valid = (state == ST_CAPTURE) && !full_pend && i_sample_valid;

    // Ownership is judged on the request cycle, so a read issued together
    // with a run edge in FULL still gets real BRAM data.
    assign host_rd = bus.i_rd_req && host_owns(state);

    mem_log_decim #(
        .DECIM_WIDTH (DECIM_WIDTH)
    ) u_decim (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_valid (cap_valid),
        .i_load  (load),
        .i_decim (decim_lat),
        .o_keep  (keep)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            run_d     <= 1'b0;
            decim_lat <= '0;
            wr_addr   <= '0;
            full_pend <= 1'b0;
            mem_full  <= 1'b0;
        end else begin
            run_d <= i_run_log;
            case (state)
                ST_IDLE, ST_FULL: begin
                    if (run_edge) begin
                        decim_lat <= i_decim;
                        wr_addr   <= '0;
                        full_pend <= 1'b0;
                        mem_full  <= 1'b0;
                        state     <= RUN_STATE;
                    end
                end
`ifdef LOG_TRIGGER_EN
                ST_ARMED: begin
                    if (i_trigger) begin
                        state <= ST_CAPTURE;
                    end
                end
`endif
                ST_CAPTURE: begin
                    if (full_pend) begin
                        full_pend <= 1'b0;
                        mem_full  <= 1'b1;
                        state     <= ST_FULL;
                    end else if (keep) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (&wr_addr) begin
                            full_pend <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- p0: registered BRAM port (capture write or host read address) ----
    always_ff @(posedge clk) begin
        if (i_rst) begin
            bram_we_p0    <= 1'b0;
            bram_addr_p0  <= '0;
            bram_wdata_p0 <= '0;
            rd_vld_p      <= '0;
            rd_host_p     <= '0;
        end else begin
            bram_we_p0 <= keep;
            if (keep) begin
                bram_addr_p0  <= wr_addr;
                bram_wdata_p0 <= i_sample;
            end else if (host_rd) begin
                bram_addr_p0 <= bus.i_rd_addr;
            end
            // ---- p1: BRAM output; valid/ownership travel alongside ----
            rd_vld_p  <= {rd_vld_p[RD_LAT-2:0], bus.i_rd_req};
            rd_host_p <= {rd_host_p[RD_LAT-2:0], host_rd};
        end
    end

    assign bus.o_bram_we    = bram_we_p0;
    assign bus.o_bram_addr  = bram_addr_p0;
    assign bus.o_bram_wdata = bram_wdata_p0;

    // Requests made while capture owned the port return zero data.
    assign bus.o_rd_valid = rd_vld_p[RD_LAT-1];
    assign bus.o_rd_data  = rd_host_p[RD_LAT-1] ? 32'(bus.i_bram_rdata) : 32'd0;

    assign o_mem_full = mem_full;
    assign o_busy     = (state == ST_ARMED) || (state == ST_CAPTURE);

endmodule

// File: tb/tb_mem_log_ctrl.sv
// Testbench for mem_log_ctrl with a 16-deep BRAM (ADDR_WIDTH=4).
// A behavioural BRAM sits on the port; the reference model keeps every
// (decim+1)-th valid sample counted from the start of capture and predicts
// write cycles, addresses, data, full timing and read responses.
module tb_mem_log_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
`ifdef LOG_TRIGGER_EN
    localparam int TRIG_BUILD = 1;
`else
    localparam int TRIG_BUILD = 0;
`endif

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_sample_valid;
    logic [DW-1:0] i_sample;
    logic [7:0]    i_decim;
    logic          i_run_log;
    logic          i_trigger;
    logic          o_mem_full;
    logic          o_busy;

    mem_log_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_log_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DECIM_WIDTH (8)
    ) dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_decim        (i_decim),
        .i_run_log      (i_run_log),
        .i_trigger      (i_trigger),
        .bus            (bus),
        .o_mem_full     (o_mem_full),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  we_viol = 0;
    bit  have_full = 0;
    int  ref_mem [DEPTH];
    ev_t wr_log[$];
    ev_t rd_log[$];
    logic [DW-1:0] bram [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.o_bram_we === 1'b1) bram[bus.o_bram_addr] <= bus.o_bram_wdata;
        bus.i_bram_rdata <= bram[bus.o_bram_addr];
    end

    always @(negedge clk) begin
        ev_t e;
        if (bus.o_bram_we === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus.o_bram_addr); e.data = int'(bus.o_bram_wdata);
            wr_log.push_back(e);
            if (o_busy !== 1'b1) we_viol++;
        end
        if (bus.o_rd_valid === 1'b1) begin
            e.cyc = cyc; e.addr = 0; e.data = int'(bus.o_rd_data);
            rd_log.push_back(e);
        end
    end

    task automatic test_reset();
        i_rst = 1'b1; i_sample_valid = 0; i_sample = '0; i_decim = '0;
        i_run_log = 0; i_trigger = 0; bus.i_rd_req = 0; bus.i_rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.o_bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.o_bram_we); end
        n_tests++; if (bus.o_bram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.o_bram_addr); end
        n_tests++; if (bus.o_bram_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", bus.o_bram_wdata); end
        n_tests++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.o_rd_valid); end
        n_tests++; if (bus.o_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", bus.o_rd_data); end
        n_tests++; if (o_mem_full !== 1'b0) begin n_fail++; $display("FAIL reset_mem_full got %b want 0", o_mem_full); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        @(posedge clk); #1;
        i_rst = 1'b0;
    endtask

    // One full capture run. d: decimation, vpct: valid probability in %,
    // arm_wait: cycles trigger stays low (trigger build only), rd_mix: random
    // host reads throughout, rd_at_edge: read issued with the run edge,
    // run_toggle: extra run edge mid-capture, seq: samples 1,2,3,...
    task automatic do_capture(input string name, input int d, input int vpct,
                              input int arm_wait, input bit rd_mix,
                              input bit rd_at_edge, input bit run_toggle,
                              input bit seq);
        ev_t exp_wr[$];
        ev_t exp_rd[$];
        ev_t e;
        int  r, c, cap_start, full_cyc, mf_cyc, busy_bad, mf_at_start;
        int  v_idx, a, s, smp, viol0;
        bit  done, exp_busy;

        wr_log.delete(); rd_log.delete();
        viol0 = we_viol;
        @(posedge clk); #1;
        i_run_log = 0; i_sample_valid = 0; bus.i_rd_req = 0; i_trigger = 0;
        i_decim = 8'(d);

        done = 0; v_idx = 0; a = 0; s = 1; full_cyc = -1; mf_cyc = -1;
        busy_bad = -1; mf_at_start = -1; r = 0; cap_start = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            c = cyc;
            if (k == 0) begin
                r = c;
                cap_start = (TRIG_BUILD != 0) ? r + 2 + arm_wait : r + 1;
            end
            i_run_log = !(run_toggle && k == 10);
            i_trigger = (TRIG_BUILD != 0) && (c >= r + 1 + arm_wait);

            i_sample_valid = ($urandom_range(99) < vpct);
            smp = seq ? s : int'($urandom_range(65535));
            i_sample = DW'(smp);
            if (i_sample_valid) s++;
            if (i_sample_valid && c >= cap_start && !done) begin
                if (v_idx % (d + 1) == 0) begin
                    e.cyc = c + 1; e.addr = a; e.data = smp;
                    exp_wr.push_back(e);
                    ref_mem[a] = smp;
                    a++;
                    if (a == DEPTH) begin done = 1; full_cyc = c + 2; end
                end
                v_idx++;
            end

            bus.i_rd_req = 0;
            if (k == 0) begin
                if (rd_at_edge && have_full) begin
                    bus.i_rd_req = 1; bus.i_rd_addr = AW'(5);
                    e.cyc = c + 2; e.addr = 5; e.data = ref_mem[5];
                    exp_rd.push_back(e);
                end
            end else if (rd_mix && $urandom_range(2) == 0) begin
                bus.i_rd_req = 1; bus.i_rd_addr = AW'($urandom_range(DEPTH - 1));
                e.cyc = c + 2; e.addr = int'(bus.i_rd_addr);
                e.data = (done && c >= full_cyc) ? ref_mem[e.addr] : 0;
                exp_rd.push_back(e);
            end

            @(negedge clk);
            if (c == r + 1) mf_at_start = int'(o_mem_full);
            if (c > r && o_mem_full === 1'b1 && mf_cyc < 0) mf_cyc = c;
            if (c > r) begin
                exp_busy = !(done && c >= full_cyc);
                if (o_busy !== exp_busy && busy_bad < 0) busy_bad = c;
            end
            if (done && c >= full_cyc + 4) break;
        end
        @(posedge clk); #1;
        bus.i_rd_req = 0; i_sample_valid = 0;
        repeat (3) @(negedge clk);

        n_tests++;
        if (!done) begin n_fail++; $display("FAIL %s_timeout got %0d writes want %0d", name, a, DEPTH); end
        n_tests++;
        if (wr_log.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL %s_wr_count got %0d want %0d", name, wr_log.size(), exp_wr.size());
        end
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            n_tests++;
            if (wr_log[i].cyc != exp_wr[i].cyc - r || wr_log[i].addr != exp_wr[i].addr ||
                wr_log[i].data != exp_wr[i].data) begin
                if (wr_log[i].cyc - r != exp_wr[i].cyc - r || wr_log[i].addr != exp_wr[i].addr ||
                    wr_log[i].data != exp_wr[i].data) begin
                    n_fail++;
                    $display("FAIL %s_wr[%0d] got cyc+%0d addr %0d data %h want cyc+%0d addr %0d data %h",
                             name, i, wr_log[i].cyc - r, wr_log[i].addr, wr_log[i].data,
                             exp_wr[i].cyc - r, exp_wr[i].addr, exp_wr[i].data);
                end
            end
        end
        n_tests++;
        if (mf_at_start != 0) begin n_fail++; $display("FAIL %s_mem_full_clear got %0d want 0", name, mf_at_start); end
        n_tests++;
        if (mf_cyc != full_cyc) begin n_fail++; $display("FAIL %s_mem_full_cyc got +%0d want +%0d", name, mf_cyc - r, full_cyc - r); end
        n_tests++;
        if (busy_bad >= 0) begin n_fail++; $display("FAIL %s_busy wrong at +%0d got %b", name, busy_bad - r, o_busy); end
        n_tests++;
        if (we_viol != viol0) begin n_fail++; $display("FAIL %s_we_host got %0d writes while idle want 0", name, we_viol - viol0); end
        n_tests++;
        if (rd_log.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL %s_rd_count got %0d want %0d", name, rd_log.size(), exp_rd.size());
        end
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) begin
            n_tests++;
            if (rd_log[i].cyc != exp_rd[i].cyc || rd_log[i].data != exp_rd[i].data) begin
                n_fail++;
                $display("FAIL %s_rd[%0d] got cyc+%0d data %h want cyc+%0d data %h", name, i,
                         rd_log[i].cyc - r, rd_log[i].data, exp_rd[i].cyc - r, exp_rd[i].data);
            end
        end
        if (done) have_full = 1;
    endtask

    task automatic test_read_back_to_back(input string name, input int n, input bit rnd);
        ev_t exp_rd[$];
        ev_t e;
        int  c0, ad;
        rd_log.delete();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (k == 0) c0 = cyc;
            ad = rnd ? int'($urandom_range(DEPTH - 1)) : 3 + k;
            bus.i_rd_req = 1; bus.i_rd_addr = AW'(ad);
            e.cyc = cyc + 2; e.addr = ad; e.data = ref_mem[ad];
            exp_rd.push_back(e);
        end
        @(posedge clk); #1;
        bus.i_rd_req = 0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (rd_log.size() != exp_rd.size()) begin
            n_fail++; $display("FAIL %s_count got %0d want %0d", name, rd_log.size(), exp_rd.size());
        end
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) begin
            n_tests++;
            if (rd_log[i].cyc != exp_rd[i].cyc || rd_log[i].data != exp_rd[i].data) begin
                n_fail++;
                $display("FAIL %s[%0d] got cyc+%0d data %h want cyc+%0d data %h", name, i,
                         rd_log[i].cyc - c0, rd_log[i].data, exp_rd[i].cyc - c0, exp_rd[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        i_decim = 0; i_run_log = 0; i_sample_valid = 0; i_trigger = 1;
        @(posedge clk); #1;
        i_run_log = 1;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            i_sample_valid = 1; i_sample = DW'($urandom_range(65535));
            @(negedge clk);
            if (bus.o_bram_we === 1'b1 && bus.o_bram_addr === AW'(7)) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rst_mid_timeout got no write to 7 want one"); end
        @(posedge clk); #1;
        i_rst = 1; i_run_log = 0; i_sample_valid = 0; i_trigger = 0;
        @(posedge clk); #1;
        i_rst = 0;
        @(negedge clk);
        n_tests++; if (bus.o_bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we got %b want 0", bus.o_bram_we); end
        n_tests++; if (bus.o_bram_addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr got %h want 0", bus.o_bram_addr); end
        n_tests++; if (bus.o_bram_wdata !== '0) begin n_fail++; $display("FAIL rst_mid_wdata got %h want 0", bus.o_bram_wdata); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", o_busy); end
        n_tests++; if (o_mem_full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_full got %b want 0", o_mem_full); end
        n_tests++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_valid got %b want 0", bus.o_rd_valid); end
        have_full = 0;
    endtask

    initial begin
        test_reset();
        do_capture("fill_d0", 0, 100, 0, 0, 0, 0, 0);
        test_read_back_to_back("rd_345", 3, 0);
        do_capture("decim2", 2, 100, 0, 0, 1, 0, 1);
        do_capture("rd_in_capture", 1, 100, 0, 1, 0, 0, 0);
        do_capture("trigger", 0, 100, 50, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_capture("random", int'($urandom_range(3)), 60, int'($urandom_range(8)), 1, 1, 1, 0);
        end
        test_read_back_to_back("rd_random", 12, 1);
        test_reset_mid();
        do_capture("restart", 0, 100, 0, 1, 0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
